button_conditioner: RTL and testbench

- Conditions the raw, active-low push-button inputs before they reach the top-level LED/throb logic.
- Each button gets three stages: a two-flop synchronizer, a per-button debounce counter, and edge/hold event generation.
- The consumer gets a clean active-high level per button, single-cycle press/release pulses, and a single-cycle long-press pulse.
- Instantiated once at top level between the button pins and the LED control block.

---
 rtl/button_conditioner.sv | 102 ++++++++++
 tb/tb_button_conditioner.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Raw active-low push-button conditioner: sync, debounce, edge and long-press events.
// One independent channel per button; outputs are active high.
module button_conditioner #(
  parameter int NUM_BUTTONS     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] button,
  output logic [NUM_BUTTONS-1:0] button_level,
  output logic [NUM_BUTTONS-1:0] button_press,
  output logic [NUM_BUTTONS-1:0] button_release,
  output logic [NUM_BUTTONS-1:0] button_hold
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE    = DW'(1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          sample;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          hold_q, hold_d;

    always_comb begin
      sync1_d   = button[g];
      sync2_d   = sync1_q;
      sample    = ~sync2_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      db_cnt_d  = db_cnt_q;

      // any sample agreeing with the accepted level restarts the count
      if (sample == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        level_d   = sample;
        db_cnt_d  = '0;
        press_d   = sample;
        release_d = ~sample;
      end else begin
        db_cnt_d = db_cnt_q + DB_ONE;
      end
    end

    always_comb begin
      hold_cnt_d = hold_cnt_q;
      hold_d     = 1'b0;

      // saturating count keeps the pulse to one per press
      if (!level_q) begin
        hold_cnt_d = '0;
      end else if (hold_cnt_q != HOLD_MAX) begin
        hold_cnt_d = hold_cnt_q + HOLD_ONE;
        hold_d     = (hold_cnt_q == HOLD_LAST) && !release_d;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        sync1_q    <= 1'b1;
        sync2_q    <= 1'b1;
        db_cnt_q   <= '0;
        hold_cnt_q <= '0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        hold_q     <= 1'b0;
      end else begin
        sync1_q    <= sync1_d;
        sync2_q    <= sync2_d;
        db_cnt_q   <= db_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        level_q    <= level_d;
        press_q    <= press_d;
        release_q  <= release_d;
        hold_q     <= hold_d;
      end
    end

    assign button_level[g]   = level_q;
    assign button_press[g]   = press_q;
    assign button_release[g] = release_q;
    assign button_hold[g]    = hold_q;

  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce and hold windows.
// Inputs change on the falling edge; outputs are checked there too.
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [1:0] button;
  logic [1:0] button_level;
  logic [1:0] button_press;
  logic [1:0] button_release;
  logic [1:0] button_hold;

  int vectors;
  int miscompares;

  button_conditioner #(
    .NUM_BUTTONS    (2),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button        (button),
    .button_level  (button_level),
    .button_press  (button_press),
    .button_release(button_release),
    .button_hold   (button_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag,
                       input logic [1:0] l, input logic [1:0] p,
                       input logic [1:0] r, input logic [1:0] h);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {button_level, button_press, button_release, button_hold};
    exp = {l, p, r, h};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed lvl=%b prs=%b rel=%b hld=%b expected lvl=%b prs=%b rel=%b hld=%b",
             tag, obs[7:6], obs[5:4], obs[3:2], obs[1:0],
             exp[7:6], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  task automatic step(input string tag,
                      input logic [1:0] l, input logic [1:0] p,
                      input logic [1:0] r, input logic [1:0] h);
    tick();
    check(tag, l, p, r, h);
  endtask

  task automatic idle(input int n, input string tag, input logic [1:0] l);
    for (int i = 0; i < n; i++) step(tag, l, 2'b00, 2'b00, 2'b00);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    button      = 2'b00;

    idle(3, "reset", 2'b00);
    rst    = 1'b1;
    button = 2'b11;
    idle(5, "idle_after_reset", 2'b00);

    button = 2'b10;
    idle(5, "cp_wait", 2'b00);
    step("cp_press", 2'b01, 2'b01, 2'b00, 2'b00);
    step("cp_after", 2'b01, 2'b00, 2'b00, 2'b00);
    button = 2'b11;
    idle(5, "cp_rel_wait", 2'b01);
    step("cp_release", 2'b00, 2'b00, 2'b01, 2'b00);
    step("cp_idle", 2'b00, 2'b00, 2'b00, 2'b00);

    button = 2'b10;
    idle(3, "glitch_low", 2'b00);
    button = 2'b11;
    idle(5, "glitch_high", 2'b00);

    button = 2'b10;
    idle(3, "bounce_low", 2'b00);
    button = 2'b11;
    idle(1, "bounce_high", 2'b00);
    button = 2'b10;
    idle(5, "bounce_settle", 2'b00);
    step("bounce_press", 2'b01, 2'b01, 2'b00, 2'b00);
    button = 2'b11;
    idle(5, "bounce_rel_wait", 2'b01);
    step("bounce_release", 2'b00, 2'b00, 2'b01, 2'b00);
    step("bounce_idle", 2'b00, 2'b00, 2'b00, 2'b00);

    button = 2'b01;
    idle(5, "lp_wait", 2'b00);
    step("lp_press", 2'b10, 2'b10, 2'b00, 2'b00);
    idle(9, "lp_count", 2'b10);
    step("lp_hold", 2'b10, 2'b00, 2'b00, 2'b10);
    idle(9, "lp_no_rehold", 2'b10);
    button = 2'b11;
    idle(5, "lp_rel_wait", 2'b10);
    step("lp_release", 2'b00, 2'b00, 2'b10, 2'b00);
    step("lp_idle", 2'b00, 2'b00, 2'b00, 2'b00);

    button = 2'b10;
    idle(5, "sp_wait", 2'b00);
    step("sp_press", 2'b01, 2'b01, 2'b00, 2'b00);
    idle(2, "sp_held", 2'b01);
    button = 2'b11;
    idle(5, "sp_rel_wait", 2'b01);
    step("sp_release", 2'b00, 2'b00, 2'b01, 2'b00);
    idle(3, "sp_no_hold", 2'b00);

    button = 2'b10;
    idle(5, "rm_wait", 2'b00);
    step("rm_press", 2'b01, 2'b01, 2'b00, 2'b00);
    idle(4, "rm_partial", 2'b01);
    rst = 1'b0;
    step("rm_reset", 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b1;
    idle(5, "rm_redebounce", 2'b00);
    step("rm_repress", 2'b01, 2'b01, 2'b00, 2'b00);
    idle(9, "rm_recount", 2'b01);
    step("rm_hold", 2'b01, 2'b00, 2'b00, 2'b01);
    button = 2'b11;
    idle(5, "rm_rel_wait", 2'b01);
    step("rm_release", 2'b00, 2'b00, 2'b01, 2'b00);
    step("rm_idle", 2'b00, 2'b00, 2'b00, 2'b00);

    button = 2'b00;
    idle(5, "both_wait", 2'b00);
    step("both_press", 2'b11, 2'b11, 2'b00, 2'b00);
    step("both_after", 2'b11, 2'b00, 2'b00, 2'b00);
    button = 2'b11;
    idle(5, "both_rel_wait", 2'b11);
    step("both_release", 2'b00, 2'b00, 2'b11, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
